axi_lite_read_slave: RTL and testbench

AXI4-Lite read-path responder: accepts read addresses on the AR channel, buffers up to two outstanding requests, and returns data with a response code on the R channel. It serves a local bank of 32-bit registers, written through a simple side port. It is the read-direction counterpart of the write-response channel logic in the same AXI4-Lite interconnect.

---
 rtl/axi_lite_read_slave_if.sv | 26 ++
 rtl/axi_lite_read_slave.sv | 85 ++++++++
 tb/tb_axi_lite_read_slave.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_read_slave_if.sv
// axi_lite_read_slave_if: AXI4-Lite AR/R channels plus the local register write port
interface axi_lite_read_slave_if #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
);
   localparam int IDX_W = $clog2(NUM_REGS);
   logic              ARVALID;
   logic              ARREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic              RVALID;
   logic              RREADY;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              REG_WE;
   logic [IDX_W-1:0]  REG_WADDR;
   logic [DATA_W-1:0] REG_WDATA;
   modport master (
      output ARVALID, ARADDR, RREADY, REG_WE, REG_WADDR, REG_WDATA,
      input  ARREADY, RVALID, RDATA, RRESP
   );
   modport slave (
      input  ARVALID, ARADDR, RREADY, REG_WE, REG_WADDR, REG_WDATA,
      output ARREADY, RVALID, RDATA, RRESP
   );
endinterface

// File: rtl/axi_lite_read_slave.sv
// axi_lite_read_slave: two-deep AR buffer feeding a registered R stage that reads a local register bank
module axi_lite_read_slave #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   axi_lite_read_slave_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_REGS);
   logic [DATA_W-1:0] r_bank [NUM_REGS];
   logic [ADDR_W-1:0] r_fifo [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;
   logic              r_arready;
   logic              r_rvalid;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_rresp;
   logic              w_push;
   logic              w_free;
   logic              w_pop;
   logic [1:0]        w_count_next;
   logic [ADDR_W-1:0] w_head;
   logic [ADDR_W-3:0] w_idx;
   logic [1:0]        w_resp;
   logic [DATA_W-1:0] w_data;

   // handshakes, next occupancy and decode of the FIFO head (out-of-range = any index bit above IDX_W set)
   always_comb begin
      w_push       = bus.ARVALID && r_arready;
      w_free       = !r_rvalid || bus.RREADY;
      w_pop        = w_free && (r_count != 2'd0);
      w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
      w_head       = r_fifo[r_rd_ptr];
      w_idx        = w_head[ADDR_W-1:2];
      w_resp       = (w_head[1:0] != 2'b00) ? 2'b10 : ((w_idx >> IDX_W) != '0) ? 2'b11 : 2'b00;
      w_data       = (w_resp == 2'b00) ? r_bank[w_idx[IDX_W-1:0]] : '0;
   end

   // local register bank, written from the side port
   always_ff @(posedge ACLK) begin
      if (!ARESETn) r_bank <= '{default: '0};
      else if (bus.REG_WE) r_bank[bus.REG_WADDR] <= bus.REG_WDATA;
   end

   // request FIFO pointers/count and registered ARREADY
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
         r_arready <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.ARADDR;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count   <= w_count_next;
         r_arready <= w_count_next < 2'd2;
      end
   end

   // R output stage: reload only when free, data/resp hold while idle or stalled
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= 2'b00;
      end else if (w_free) begin
         r_rvalid <= w_pop;
         if (w_pop) begin
            r_rdata <= w_data;
            r_rresp <= w_resp;
         end
      end
   end

   assign bus.ARREADY = r_arready;
   assign bus.RVALID  = r_rvalid;
   assign bus.RDATA   = r_rdata;
   assign bus.RRESP   = r_rresp;
endmodule

// File: tb/tb_axi_lite_read_slave.sv
// tb_axi_lite_read_slave: vector table plus scoreboard check of the AXI4-Lite read responder
module tb_axi_lite_read_slave;
   localparam int ADDR_W = 8, DATA_W = 32, NUM_REGS = 16;
   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;
   typedef struct {
      logic [7:0]  addr;
      logic [1:0]  resp;
      logic [31:0] data;
   } vec_t;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] m_bank [NUM_REGS];
   exp_t exp_q [$];
   vec_t vt [10];

   always #5 ACLK = ~ACLK;

   axi_lite_read_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) bus ();
   axi_lite_read_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus.slave));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a);
      exp_t e;
      e.data = '0;
      if (a[1:0] != 2'b00) e.resp = 2'b10;
      else if (a[7:2] >= 6'd16) e.resp = 2'b11;
      else begin
         e.resp = 2'b00;
         e.data = m_bank[a[5:2]];
      end
      return e;
   endfunction

   // scoreboard: values seen at negedge are the ones the next rising edge acts on
   always @(negedge ACLK) begin
      exp_t e;
      if (!ARESETn) exp_q.delete();
      else begin
         if (bus.RVALID && bus.RREADY) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_unexpected: got R beat %0h, required none", bus.RDATA);
            end else begin
               e = exp_q.pop_front();
               check("sb_rresp", 64'(bus.RRESP), 64'(e.resp));
               check("sb_rdata", 64'(bus.RDATA), 64'(e.data));
            end
         end
         if (bus.ARVALID && bus.ARREADY) exp_q.push_back(model(bus.ARADDR));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic wr(input int i, input logic [31:0] d);
      bus.REG_WE    = 1'b1;
      bus.REG_WADDR = 4'(i);
      bus.REG_WDATA = d;
      m_bank[i]     = d;
      tick();
      bus.REG_WE    = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [1:0] resp, output logic [31:0] data, output int lat);
      int w = 0;
      bus.RREADY  = 1'b1;
      bus.ARVALID = 1'b1;
      bus.ARADDR  = a;
      while (!bus.ARREADY && w < 20) begin
         tick();
         w++;
      end
      tick();
      bus.ARVALID = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.RVALID && lat < 20);
      resp = bus.RRESP;
      data = bus.RDATA;
   endtask

   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      logic [31:0] got [$];
      logic [7:0]  addrs [4];
      int          lat;
      int          k;
      int          quiet;
      logic        acc;
      vt[0] = '{8'h0C, 2'b00, 32'hDEADBEEF};
      vt[1] = '{8'h0D, 2'b10, 32'h0};
      vt[2] = '{8'h40, 2'b11, 32'h0};
      vt[3] = '{8'h3C, 2'b00, 32'h0000F00D};
      vt[4] = '{8'h00, 2'b00, 32'h000000A0};
      vt[5] = '{8'h04, 2'b00, 32'h000000A1};
      vt[6] = '{8'hFF, 2'b10, 32'h0};
      vt[7] = '{8'hFC, 2'b11, 32'h0};
      vt[8] = '{8'h3E, 2'b10, 32'h0};
      vt[9] = '{8'h10, 2'b00, 32'h0};
      addrs = '{8'h00, 8'h04, 8'h08, 8'h0C};
      for (int i = 0; i < NUM_REGS; i++) m_bank[i] = '0;
      bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.RREADY = 1'b0;
      bus.REG_WE = 1'b0; bus.REG_WADDR = '0; bus.REG_WDATA = '0;

      ARESETn = 1'b0;
      repeat (3) tick();
      check("rst_arready", 64'(bus.ARREADY), 64'd0);
      check("rst_rvalid", 64'(bus.RVALID), 64'd0);
      check("rst_rdata", 64'(bus.RDATA), 64'd0);
      check("rst_rresp", 64'(bus.RRESP), 64'd0);
      ARESETn = 1'b1;
      tick();
      check("rel_arready", 64'(bus.ARREADY), 64'd1);

      wr(3, 32'hDEADBEEF);
      wr(0, 32'hA0);
      wr(1, 32'hA1);
      wr(2, 32'hA2);
      wr(15, 32'hF00D);
      wr(5, 32'h11);

      for (int i = 0; i < 10; i++) begin
         rd(vt[i].addr, resp, data, lat);
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'd1);
         check($sformatf("vec%0d_rresp", i), 64'(resp), 64'(vt[i].resp));
         check($sformatf("vec%0d_rdata", i), 64'(data), 64'(vt[i].data));
         tick();
         check($sformatf("vec%0d_rvalid_drop", i), 64'(bus.RVALID), 64'd0);
      end

      bus.RREADY = 1'b0;
      k = 0;
      bus.ARVALID = 1'b1;
      bus.ARADDR = addrs[0];
      for (int c = 0; c < 8; c++) begin
         acc = bus.ARVALID && bus.ARREADY;
         tick();
         if (acc) k++;
         if (k < 4) bus.ARADDR = addrs[k];
      end
      check("bp_accepted", 64'(k), 64'd3);
      check("bp_arready", 64'(bus.ARREADY), 64'd0);
      check("bp_rvalid", 64'(bus.RVALID), 64'd1);
      check("bp_rdata_stable", 64'(bus.RDATA), 64'hA0);
      bus.RREADY = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (bus.RVALID && bus.RREADY) got.push_back(bus.RDATA);
         acc = bus.ARVALID && bus.ARREADY;
         tick();
         if (acc) begin
            k++;
            bus.ARVALID = 1'b0;
         end
      end
      check("bp_late_accept", 64'(k), 64'd4);
      check("bp_beats", 64'(got.size()), 64'd4);
      if (got.size() == 4) begin
         check("bp_order0", 64'(got[0]), 64'hA0);
         check("bp_order1", 64'(got[1]), 64'hA1);
         check("bp_order2", 64'(got[2]), 64'hA2);
         check("bp_order3", 64'(got[3]), 64'hDEADBEEF);
      end

      bus.ARVALID = 1'b1;
      bus.ARADDR = 8'h14;
      tick();
      bus.ARVALID = 1'b0;
      wr(5, 32'h22);
      check("col_rvalid", 64'(bus.RVALID), 64'd1);
      check("col_rdata_old", 64'(bus.RDATA), 64'h11);
      tick();
      rd(8'h14, resp, data, lat);
      check("col_rdata_new", 64'(data), 64'h22);
      tick();

      bus.RREADY = 1'b0;
      k = 0;
      bus.ARVALID = 1'b1;
      bus.ARADDR = addrs[0];
      for (int c = 0; c < 6; c++) begin
         acc = bus.ARVALID && bus.ARREADY;
         tick();
         if (acc) k++;
         if (k < 4) bus.ARADDR = addrs[k];
      end
      bus.ARVALID = 1'b0;
      check("mr_outstanding", 64'(k), 64'd3);
      check("mr_rvalid_before", 64'(bus.RVALID), 64'd1);
      ARESETn = 1'b0;
      tick();
      ARESETn = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) m_bank[i] = '0;
      check("mr_rvalid_reset", 64'(bus.RVALID), 64'd0);
      check("mr_arready_reset", 64'(bus.ARREADY), 64'd0);
      bus.RREADY = 1'b1;
      quiet = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.RVALID) quiet++;
      end
      check("mr_no_stale", 64'(quiet), 64'd0);
      rd(8'h00, resp, data, lat);
      check("mr_cleared_resp", 64'(resp), 64'd0);
      check("mr_cleared_data", 64'(data), 64'd0);
      repeat (3) tick();
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
